// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage HI/LO multiply/divide unit: md_op encodings,
// default latencies and the decoder constants that produce md_op/start.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;

    // Decoder helper: is_md says whether the instruction drives start at all.
    function automatic logic [3:0] decode_md(input logic [5:0] opcode, input logic [5:0] funct);
        logic       is_md;
        logic [2:0] op;
        is_md = (opcode == OP_SPECIAL);
        op    = 3'd7;
        case (funct)
            FN_MULT:  op = MD_MULT;
            FN_MULTU: op = MD_MULTU;
            FN_DIV:   op = MD_DIV;
            FN_DIVU:  op = MD_DIVU;
            FN_MTHI:  op = MD_MTHI;
            FN_MTLO:  op = MD_MTLO;
            default:  is_md = 1'b0;
        endcase
        return {is_md, op};
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for mult/multu/div/divu; valid is low when
// the result must not be committed (divide by zero, non-arithmetic ops).
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] divisor_s;
    logic signed [31:0] quo_s;
    logic signed [31:0] rem_s;
    logic        [31:0] divisor_u;
    logic        [31:0] quo_u;
    logic        [31:0] rem_u;
    logic               b_zero;
    logic               div_ovf;

    assign a_s    = $signed(a);
    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'b0, a} * {32'b0, b};

    assign b_zero  = (b == 32'h0);
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Dividing by 1 in the overflow case yields exactly LO=0x80000000, HI=0,
    // and keeps the divider free of zero/overflow operands.
    assign divisor_s = (b_zero || div_ovf) ? 32'sd1 : $signed(b);
    assign divisor_u = b_zero ? 32'd1 : b;
    assign quo_s     = a_s / divisor_s;
    assign rem_s     = a_s % divisor_s;
    assign quo_u     = a / divisor_u;
    assign rem_u     = a % divisor_u;

    always_comb begin
        hi    = 32'h0;
        lo    = 32'h0;
        valid = 1'b0;
        case (md_op)
            MD_MULT: begin
                hi    = prod_s[63:32];
                lo    = prod_s[31:0];
                valid = 1'b1;
            end
            MD_MULTU: begin
                hi    = prod_u[63:32];
                lo    = prod_u[31:0];
                valid = 1'b1;
            end
            MD_DIV: begin
                hi    = rem_s;
                lo    = quo_s;
                valid = ~b_zero;
            end
            MD_DIVU: begin
                hi    = rem_u;
                lo    = quo_u;
                valid = ~b_zero;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// E-stage HI/LO unit: multi-cycle mult/div with a busy counter, single-cycle mthi/mtlo,
// and a combinational HI/LO read port feeding the E/M register.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        sel_hi,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] md_out
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state;
    state_e             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_vld;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               res_vld;
    logic               accept;
    logic               is_long;
    logic               is_mult;
    logic               load;
    logic               commit;

    mdu_arith u_arith (
        .md_op (md_op),
        .a     (rs_val),
        .b     (rt_val),
        .hi    (res_hi),
        .lo    (res_lo),
        .valid (res_vld)
    );

    assign busy    = (state == RUN);
    assign accept  = start & ~flush & ~busy;
    assign is_mult = (md_op == MD_MULT) || (md_op == MD_MULTU);
    assign is_long = is_mult || (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign md_out  = sel_hi ? hi : lo;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (accept && is_long) begin
                    state_n = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    commit  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Operands are captured at the accept edge; HI/LO only move at commit or mthi/mtlo.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            hi       <= 32'h0;
            lo       <= 32'h0;
            pend_hi  <= 32'h0;
            pend_lo  <= 32'h0;
            pend_vld <= 1'b0;
        end else begin
            if (load) begin
                pend_hi  <= res_hi;
                pend_lo  <= res_lo;
                pend_vld <= res_vld;
                cnt      <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            end else if (busy) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit && pend_vld) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
            if (accept && (md_op == MD_MTHI)) hi <= rs_val;
            if (accept && (md_op == MD_MTLO)) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed HI/LO results, busy timing,
// flush/ignored-start/reset-abort corner cases.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        sel_hi;
    logic        flush;
    logic        busy;
    logic [31:0] md_out;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .sel_hi (sel_hi),
        .flush  (flush),
        .busy   (busy),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] sel_save;
        sel_save = {31'b0, sel_hi};
        sel_hi = 1'b1;
        #1;
        check({tag, "_hi"}, md_out, exp_hi);
        sel_hi = 1'b0;
        #1;
        check({tag, "_lo"}, md_out, exp_lo);
        sel_hi = sel_save[0];
    endtask

    // One-cycle start pulse, accepted at the next edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        md_op  = op;
        rs_val = a;
        rt_val = b;
        step();
        start  = 1'b0;
        rs_val = 32'hDEAD_BEEF;
        rt_val = 32'h0BAD_F00D;
    endtask

    // busy must be high for exactly n cycles after the accept edge, HI/LO frozen meanwhile.
    task automatic expect_busy(input string tag, input int n, input logic [31:0] old_hi,
                               input logic [31:0] old_lo);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy_hi"}, {31'b0, busy}, 32'd1);
            if (i == 0 || i == n - 1) check_hilo({tag, "_frozen"}, old_hi, old_lo);
            step();
        end
        check({tag, "_busy_lo"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = 3'd0;
        rs_val = 32'h0;
        rt_val = 32'h0;
        sel_hi = 1'b0;
        flush  = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check_hilo("reset", 32'h0, 32'h0);

        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        expect_busy("mult", 5, 32'h0, 32'h0);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        expect_busy("multu", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        expect_busy("div", 10, 32'hFFFF_FFFE, 32'h0000_0001);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(MD_DIVU, 32'd7, 32'd0);
        expect_busy("divu0", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check_hilo("divu0", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        issue(MD_DIVU, 32'd100, 32'd7);
        expect_busy("divu", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check_hilo("divu", 32'd2, 32'd14);

        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_busy("div_ovf", 10, 32'd2, 32'd14);
        check_hilo("div_ovf", 32'h0, 32'h8000_0000);

        flush = 1'b1;
        issue(MD_MTHI, 32'h1234_5678, 32'h0);
        flush = 1'b0;
        check("mthi_flush_busy", {31'b0, busy}, 32'd0);
        check_hilo("mthi_flush", 32'h0, 32'h8000_0000);

        issue(MD_MTHI, 32'h1234_5678, 32'h0);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check_hilo("mthi", 32'h1234_5678, 32'h8000_0000);

        issue(MD_MTLO, 32'hCAFE_BABE, 32'h0);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        check_hilo("mtlo", 32'h1234_5678, 32'hCAFE_BABE);

        issue(3'd6, 32'h1111_1111, 32'h2222_2222);
        check("rsvd_busy", {31'b0, busy}, 32'd0);
        check_hilo("rsvd", 32'h1234_5678, 32'hCAFE_BABE);

        // Second start sampled at the 3rd busy edge must be ignored.
        issue(MD_DIV, 32'hFFFF_FF9C, 32'd7);
        for (int i = 0; i < 10; i++) begin
            check("dbl_busy_hi", {31'b0, busy}, 32'd1);
            if (i == 2) begin
                start  = 1'b1;
                md_op  = MD_MULT;
                rs_val = 32'd5;
                rt_val = 32'd5;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        check("dbl_busy_lo", {31'b0, busy}, 32'd0);
        check_hilo("dbl", 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        // Flush while running does not cancel the commit.
        issue(MD_MULTU, 32'd6, 32'd7);
        flush = 1'b1;
        expect_busy("flush_run", 5, 32'hFFFF_FFFE, 32'hFFFF_FFF2);
        flush = 1'b0;
        check_hilo("flush_run", 32'h0, 32'd42);

        // Reset at cycle 2 aborts the multiply with no late writeback.
        issue(MD_MULT, 32'd3, 32'd4);
        check("abort_busy1", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy0", {31'b0, busy}, 32'd0);
        check_hilo("abort", 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) step();
        check("abort_late_busy", {31'b0, busy}, 32'd0);
        check_hilo("abort_late", 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage HI/LO multiply/divide unit of the 5-stage MIPS pipeline.
- Sits beside the ALU in E. Its read port drives the Mult_Div value that is latched into the E/M pipeline register.
- Runs multi-cycle mult/div with a busy counter and executes mthi/mtlo.
- Supports cancellation of a start when a later stage raises an exception or interrupt (precise-exception support).

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  E-stage instruction is mult/multu/div/divu/mthi/mtlo; valid for one cycle.
- md_op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 reserved (no-op).
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- sel_hi  input  1  read select: 1 = HI, 0 = LO.
- flush  input  1  exception/interrupt committed in M; suppresses any start this cycle.
- busy  output  1  operation in flight; the hazard unit stalls any md instruction in D while (start|busy).
- md_out  output  32  combinational read of committed HI (sel_hi=1) or LO (sel_hi=0).

Behaviour:
- Reset:
  - HI=0, LO=0, busy=0, counter=0, pending HI/LO=0.
  - Reset mid-operation aborts the operation. HI/LO return to 0 and no late writeback occurs.
- Accept condition: start & ~flush & ~busy at the posedge.
  - If start arrives while busy, it is ignored (assertion-worthy; the stall logic must prevent it).
  - If flush is high, start is ignored and no state changes.
- MTHI/MTLO:
  - On acceptance, HI<=rs_val (MTHI) or LO<=rs_val (MTLO) at that edge.
  - busy stays 0. md_out reflects the new value the next cycle.
- MULT/MULTU/DIV/DIVU:
  - On acceptance, compute the result from the operands sampled at that edge into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES and set busy=1 at that edge.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1, counter decrements each cycle.
  - At the edge where counter==1: HI<=pending_hi, LO<=pending_lo, busy<=0, go to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
  - Reserved md_op codes do not leave IDLE.
- Visibility: HI/LO are unchanged during RUN. md_out shows the old values until commit and the new values from the cycle after the commit edge.
- Arithmetic:
  - MULT: signed 32x32->64, HI=upper, LO=lower.
  - MULTU: unsigned 32x32->64.
  - DIV: LO=quotient truncated toward zero, HI=remainder with the dividend's sign.
  - DIV special case 0x80000000/0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned.
  - Divide by zero: full DIV_CYCLES busy, then HI/LO left unchanged (no commit).
- flush during RUN does not abort. The instruction already passed E, so its result commits architecturally.
- Back-to-back: a new start is accepted in the cycle after busy falls, with md_out already showing the committed result.

Decomposition:
- Shared package mdu_pkg holds:
  - the md_op encodings (MD_MULT..MD_MTLO);
  - MULT_CYCLES/DIV_CYCLES defaults;
  - the opcode/funct constants used by the decoder to build md_op/start.
- One natural sub-module, mdu_arith: a combinational 64-bit result generator (mult/multu/div/divu with the special cases above). The top module holds the counter, FSM and HI/LO registers.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFE (-2), rt=3:
  - busy high for 5 cycles;
  - afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA;
  - md_out equals the old LO (0) while busy.
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2:
  - busy for 10 cycles;
  - then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A repeat with DIVU 7/0 leaves HI/LO unchanged after 10 cycles.
- MTHI 0x12345678 with flush=1 -> HI unchanged. Repeat with flush=0 -> HI=0x12345678 the next cycle, busy never asserts.
- DIV started, start pulsed again at cycle 3 -> second start ignored. Result equals the first op, and busy drops after exactly 10 cycles.
- MULT started, reset asserted at cycle 2 -> busy=0 next cycle, HI=LO=0, and no writeback at cycle 5.
